axi_txn_monitor: RTL and testbench
==================================

# axi_txn_monitor

Synthesizable, parametrised AXI4 transaction monitor for the core AXI subsystem, sitting passively on the master-side AXI ports. It replaces per-master `$write` bus logging with hardware that:
- counts outstanding read and write transactions per master;
- runs a per-master stall watchdog;
- pushes address-handshake events into a buffered event stream, drained by the testbench or a debug UART.

It never drives the bus.

## Interface
Parameters:
- NUM_MASTERS, 2, number of monitored AXI master ports (1..8)
- ADDR_WIDTH, 32, AXI address width
- OUTST_WIDTH, 4, width of each outstanding counter (saturates at 2^OUTST_WIDTH-1)
- FIFO_DEPTH, 8, event FIFO entries (power of two, ≥2)
- TIMEOUT_CYCLES, 1024, stall watchdog threshold

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  monitor clock (AXI subsystem clock)
- rst_i  in  1  synchronous active-high reset
- ar_valid_i, ar_ready_i  in  NUM_MASTERS  AR handshake per master
- ar_addr_i  in  NUM_MASTERS*ADDR_WIDTH  AR address, master i at slice i
- r_valid_i, r_ready_i, r_last_i  in  NUM_MASTERS  R channel
- aw_valid_i, aw_ready_i  in  NUM_MASTERS  AW handshake
- aw_addr_i  in  NUM_MASTERS*ADDR_WIDTH  AW address
- b_valid_i, b_ready_i  in  NUM_MASTERS  B channel
- rd_outst_o, wr_outst_o  out  NUM_MASTERS*OUTST_WIDTH  outstanding counts
- timeout_o  out  NUM_MASTERS  sticky watchdog flag
- proto_err_o  out  NUM_MASTERS  sticky protocol-violation flag
- evt_valid_o  out  1  event available
- evt_ready_i  in  1  consumer accepts event
- evt_master_o  out  $clog2(NUM_MASTERS) (min 1)  source master
- evt_write_o  out  1  1 = AW event, 0 = AR event
- evt_addr_o  out  ADDR_WIDTH  handshaked address
- drop_cnt_o  out  16  events dropped (saturating)

## Operation
- Handshake means valid&ready in the same cycle.
- Read counter, per master:
  - +1 on an AR handshake.
  - −1 on an R handshake with r_last.
  - Both in one cycle: unchanged.
  - Saturates at max and floors at 0; a decrement at 0 sets proto_err_o (when checks are compiled in).
- Write counter: +1 on AW, −1 on B, with the same rules.
- Watchdog, per master:
  - The counter increments while (rd_outst+wr_outst)≠0 and no R or B handshake occurs in the cycle.
  - It clears on any R/B handshake or when the master is idle.
  - Reaching TIMEOUT_CYCLES sets timeout_o, which stays set until reset.
- Event capture:
  - Candidates each cycle are every AR and AW handshake.
  - Fixed priority: master 0 AR, master 0 AW, master 1 AR, and so on.
  - The single winner is pushed if the FIFO is not full.
  - Every other candidate, and the winner when the FIFO is full, increments drop_cnt_o by one each (saturating at 0xFFFF).
- FIFO:
  - Standard valid/ready output; a pop occurs on evt_valid_o&evt_ready_i.
  - Push and pop in the same cycle while full is allowed; the entry is not dropped.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- All outputs are registered. Reset values: counters 0, flags 0, evt_valid_o 0, evt_* data 0, drop_cnt_o 0.
- Counters and flags update in the cycle after the handshake edge.
- Event latency: a handshake at edge N gives evt_valid_o high after edge N (visible in cycle N+1) when the FIFO was empty. There is no bypass.
- evt_* outputs hold stable while evt_valid_o&!evt_ready_i.
- Reset asserted mid-operation:
  - Clears all state, including FIFO contents, at the next edge.
  - Handshakes in that cycle are ignored.

## Configuration
- AXI_MON_PROTOCOL_CHECK_EN defined:
  - Sets proto_err_o[i] when ar_valid or aw_valid deasserts without a handshake.
  - Sets it when the corresponding address changes while valid is held and ready is low.
  - Sets it on a counter underflow.
- Not defined: proto_err_o is tied to 0 and no checker state is instantiated.

## Structure
- Package axi_mon_pkg holds:
  - the evt_t struct (master, write, addr);
  - localparam MAX_MASTERS=8;
  - function clog2_min1.
- One sub-module, axi_mon_fifo: a parametrised synchronous FIFO of evt_t with push/full and valid/ready pop ports.
- Per-master counters and the watchdog are a generate loop inside axi_txn_monitor.

## Test plan
- Single read on master 0: AR at 0x8000_0080, then 4 R beats with last on beat 4. rd_outst_o[0] goes 0→1→0, and one event {m0, read, 0x80000080} appears one cycle later.
- Simultaneous AR on master 0 and AW on master 1, with evt_ready_i=1. Only the m0 read event is queued and drop_cnt_o=1.
- evt_ready_i=0 for 10 AR handshakes with FIFO_DEPTH=8. 8 events are held in order and drop_cnt_o=2. Releasing ready drains the addresses in order.
- AW with no B response for TIMEOUT_CYCLES cycles. timeout_o[0] is set on the threshold cycle and stays set after a late B.
- With AXI_MON_PROTOCOL_CHECK_EN: ar_valid drops before ready, giving proto_err_o=1. Without the macro, the same stimulus leaves it 0.
- rst_i pulsed with 3 reads outstanding and 2 events queued. All counters are 0, evt_valid_o=0 and drop_cnt_o=0 in the next cycle.

Source files
------------

// File: rtl/axi_mon_pkg.sv
// Shared types and helpers for the AXI transaction monitor.
// Event fields are sized for the widest supported configuration; the top truncates them.
package axi_mon_pkg;

  localparam int MAX_MASTERS    = 8;
  localparam int MAX_ADDR_WIDTH = 64;
  localparam int MASTER_IDX_W   = 3;

  typedef struct packed {
    logic [MASTER_IDX_W-1:0]   master;
    logic                      write;
    logic [MAX_ADDR_WIDTH-1:0] addr;
  } evt_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_mon_fifo.sv
// Synchronous event FIFO with a registered head entry, so the pop-side outputs come
// straight from flops. A push into a full FIFO is accepted only when a pop happens in the same cycle.
module axi_mon_fifo
  import axi_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  evt_t push_data_i,
  output logic full_o,
  output logic pop_valid_o,
  input  logic pop_ready_i,
  output evt_t pop_data_o
);

  localparam int PW = $clog2(DEPTH);

  evt_t          mem_q [DEPTH];
  evt_t          head_q;
  logic [PW-1:0] wptr_q, rptr_q, rptr_nxt;
  logic [PW:0]   cnt_q, cnt_d;
  logic          valid_q, pop, push_ok;

  assign full_o      = (cnt_q == (PW+1)'(DEPTH));
  assign pop         = valid_q & pop_ready_i;
  assign push_ok     = push_i & (~full_o | pop);
  assign rptr_nxt    = rptr_q + 1'b1;
  assign cnt_d       = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
  assign pop_valid_o = valid_q;
  assign pop_data_o  = head_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      head_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_nxt;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      // A push that lands in an otherwise-empty FIFO becomes the head directly.
      if (push_ok && cnt_q == (PW+1)'(pop)) head_q <= push_data_i;
      else if (pop)                         head_q <= mem_q[rptr_nxt];
    end
  end

endmodule

// File: rtl/axi_txn_monitor.sv
// Passive AXI4 monitor: per-master outstanding counters, stall watchdog and an address event stream.
// Optional protocol checker enabled by defining AXI_MON_PROTOCOL_CHECK_EN.
module axi_txn_monitor
  import axi_mon_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int OUTST_WIDTH    = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int MW            = clog2_min1(NUM_MASTERS)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            ar_valid_i,
  input  logic [NUM_MASTERS-1:0]            ar_ready_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [NUM_MASTERS-1:0]            r_valid_i,
  input  logic [NUM_MASTERS-1:0]            r_ready_i,
  input  logic [NUM_MASTERS-1:0]            r_last_i,
  input  logic [NUM_MASTERS-1:0]            aw_valid_i,
  input  logic [NUM_MASTERS-1:0]            aw_ready_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [NUM_MASTERS-1:0]            b_valid_i,
  input  logic [NUM_MASTERS-1:0]            b_ready_i,
  output logic [NUM_MASTERS*OUTST_WIDTH-1:0] rd_outst_o,
  output logic [NUM_MASTERS*OUTST_WIDTH-1:0] wr_outst_o,
  output logic [NUM_MASTERS-1:0]            timeout_o,
  output logic [NUM_MASTERS-1:0]            proto_err_o,
  output logic                              evt_valid_o,
  input  logic                              evt_ready_i,
  output logic [MW-1:0]                     evt_master_o,
  output logic                              evt_write_o,
  output logic [ADDR_WIDTH-1:0]             evt_addr_o,
  output logic [15:0]                       drop_cnt_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_MASTERS-1:0][OUTST_WIDTH-1:0] rd_outst, wr_outst;
  logic [2*NUM_MASTERS-1:0]                cand;

  assign rd_outst_o = rd_outst;
  assign wr_outst_o = wr_outst;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    logic                   ar_hs, aw_hs, r_hs, rl_hs, b_hs, busy;
    logic                   rd_uf, wr_uf, to_q, to_d;
    logic [OUTST_WIDTH-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [TW-1:0]          wd_q, wd_d;

    assign ar_hs = ar_valid_i[i] & ar_ready_i[i];
    assign aw_hs = aw_valid_i[i] & aw_ready_i[i];
    assign r_hs  = r_valid_i[i] & r_ready_i[i];
    assign rl_hs = r_hs & r_last_i[i];
    assign b_hs  = b_valid_i[i] & b_ready_i[i];
    assign busy  = (rd_q != '0) || (wr_q != '0);

    assign cand[2*i]   = ar_hs;
    assign cand[2*i+1] = aw_hs;
    assign rd_outst[i]  = rd_q;
    assign wr_outst[i]  = wr_q;
    assign timeout_o[i] = to_q;

    always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      rd_uf = 1'b0;
      wr_uf = 1'b0;
      if (ar_hs && !rl_hs) begin
        if (rd_q != '1) rd_d = rd_q + 1'b1;
      end else if (rl_hs && !ar_hs) begin
        if (rd_q == '0) rd_uf = 1'b1;
        else            rd_d  = rd_q - 1'b1;
      end
      if (aw_hs && !b_hs) begin
        if (wr_q != '1) wr_d = wr_q + 1'b1;
      end else if (b_hs && !aw_hs) begin
        if (wr_q == '0) wr_uf = 1'b1;
        else            wr_d  = wr_q - 1'b1;
      end
      // Any response beat counts as forward progress for the watchdog.
      wd_d = '0;
      if (busy && !(r_hs || b_hs))
        wd_d = (wd_q == TW'(TIMEOUT_CYCLES)) ? wd_q : wd_q + 1'b1;
      to_d = to_q | (wd_d == TW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_q <= '0;
        wr_q <= '0;
        wd_q <= '0;
        to_q <= 1'b0;
      end else begin
        rd_q <= rd_d;
        wr_q <= wr_d;
        wd_q <= wd_d;
        to_q <= to_d;
      end
    end

`ifdef AXI_MON_PROTOCOL_CHECK_EN
    logic                  arv_q, arr_q, awv_q, awr_q, perr_q, ar_viol, aw_viol;
    logic [ADDR_WIDTH-1:0] ara_q, awa_q;

    // Last cycle held valid without ready: valid must stay up and the address must not move.
    assign ar_viol = arv_q & ~arr_q &
                     (~ar_valid_i[i] | (ar_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] != ara_q));
    assign aw_viol = awv_q & ~awr_q &
                     (~aw_valid_i[i] | (aw_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] != awa_q));
    assign proto_err_o[i] = perr_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        arv_q  <= 1'b0;
        arr_q  <= 1'b0;
        awv_q  <= 1'b0;
        awr_q  <= 1'b0;
        ara_q  <= '0;
        awa_q  <= '0;
        perr_q <= 1'b0;
      end else begin
        arv_q  <= ar_valid_i[i];
        arr_q  <= ar_ready_i[i];
        awv_q  <= aw_valid_i[i];
        awr_q  <= aw_ready_i[i];
        ara_q  <= ar_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        awa_q  <= aw_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        perr_q <= perr_q | ar_viol | aw_viol | rd_uf | wr_uf;
      end
    end
`else
    logic uf_unused;
    assign uf_unused      = rd_uf | wr_uf;
    assign proto_err_o[i] = 1'b0;
`endif
  end

  // Event arbitration: lowest candidate index wins (m0 AR, m0 AW, m1 AR, ...).
  evt_t        ev, head;
  logic        any, full, pop, accept, evt_unused;
  logic [4:0]  ncand, ndrop;
  logic [16:0] dsum;
  logic [15:0] drop_q;

  always_comb begin
    ev    = '0;
    any   = 1'b0;
    ncand = '0;
    for (int k = 2*NUM_MASTERS-1; k >= 0; k--) begin
      ncand = ncand + 5'(cand[k]);
      if (cand[k]) begin
        any       = 1'b1;
        ev.master = MASTER_IDX_W'(k >> 1);
        ev.write  = (k % 2 == 1);
        ev.addr   = (k % 2 == 1) ? MAX_ADDR_WIDTH'(aw_addr_i[(k>>1)*ADDR_WIDTH +: ADDR_WIDTH])
                                 : MAX_ADDR_WIDTH'(ar_addr_i[(k>>1)*ADDR_WIDTH +: ADDR_WIDTH]);
      end
    end
  end

  assign pop    = evt_valid_o & evt_ready_i;
  assign accept = any & (~full | pop);
  assign ndrop  = ncand - 5'(accept);
  assign dsum   = {1'b0, drop_q} + 17'(ndrop);

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= '0;
    else       drop_q <= dsum[16] ? 16'hFFFF : dsum[15:0];
  end

  axi_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (any),
    .push_data_i (ev),
    .full_o      (full),
    .pop_valid_o (evt_valid_o),
    .pop_ready_i (evt_ready_i),
    .pop_data_o  (head)
  );

  assign evt_master_o = head.master[MW-1:0];
  assign evt_write_o  = head.write;
  assign evt_addr_o   = head.addr[ADDR_WIDTH-1:0];
  assign evt_unused   = ^head;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_axi_txn_monitor.sv
// Directed bench for axi_txn_monitor: counters, event FIFO, drops, watchdog, protocol flag, reset.
module tb_axi_txn_monitor;
  localparam int NM = 2, AW = 32, OW = 4, FD = 8, TO = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic [NM-1:0] ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [NM-1:0] aw_valid, aw_ready, b_valid, b_ready;
  logic [NM*AW-1:0] ar_addr, aw_addr;
  logic [NM*OW-1:0] rd_outst, wr_outst;
  logic [NM-1:0] timeout, proto_err;
  logic          evt_valid, evt_ready, evt_write;
  logic [0:0]    evt_master;
  logic [AW-1:0] evt_addr;
  logic [15:0]   drop_cnt;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  axi_txn_monitor #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .OUTST_WIDTH(OW),
                    .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready), .ar_addr_i(ar_addr),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_addr_i(aw_addr),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .rd_outst_o(rd_outst), .wr_outst_o(wr_outst),
    .timeout_o(timeout), .proto_err_o(proto_err),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_master_o(evt_master), .evt_write_o(evt_write),
    .evt_addr_o(evt_addr), .drop_cnt_o(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ar_valid = '0; ar_ready = '0; r_valid = '0; r_ready = '0; r_last = '0;
    aw_valid = '0; aw_ready = '0; b_valid = '0; b_ready = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    ar_addr = '0; aw_addr = '0; evt_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rd", rd_outst, 0);
    chk("rst_wr", wr_outst, 0);
    chk("rst_to", timeout, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_evalid", evt_valid, 0);
    chk("rst_eaddr", evt_addr, 0);
    chk("rst_drop", drop_cnt, 0);

    // Single read on m0, 4 beats
    ar_valid = 2'b01; ar_ready = 2'b01; ar_addr[31:0] = 32'h8000_0080;
    tick();
    idle();
    chk("rd1_outst", rd_outst[3:0], 1);
    chk("rd1_evalid", evt_valid, 1);
    chk("rd1_eaddr", evt_addr, 32'h8000_0080);
    chk("rd1_emaster", evt_master, 0);
    chk("rd1_ewrite", evt_write, 0);
    for (int b = 1; b <= 4; b++) begin
      r_valid = 2'b01; r_ready = 2'b01; r_last = (b == 4) ? 2'b01 : 2'b00;
      tick();
      chk("rd1_beat", rd_outst[3:0], (b == 4) ? 0 : 1);
    end
    idle();
    chk("rd1_hold", evt_valid, 1);
    evt_ready = 1'b1;
    tick();
    chk("rd1_popped", evt_valid, 0);
    chk("rd1_perr", proto_err, 0);

    // Simultaneous m0 AR and m1 AW: only m0 read queued, one drop
    ar_valid = 2'b01; ar_ready = 2'b01; ar_addr[31:0] = 32'h0000_1000;
    aw_valid = 2'b10; aw_ready = 2'b10; aw_addr[63:32] = 32'h0000_2000;
    tick();
    idle();
    chk("sim_evalid", evt_valid, 1);
    chk("sim_eaddr", evt_addr, 32'h1000);
    chk("sim_ewrite", evt_write, 0);
    chk("sim_emaster", evt_master, 0);
    chk("sim_drop", drop_cnt, 1);
    chk("sim_rd0", rd_outst[3:0], 1);
    chk("sim_wr1", wr_outst[7:4], 1);
    r_valid = 2'b01; r_ready = 2'b01; r_last = 2'b01; b_valid = 2'b10; b_ready = 2'b10;
    tick();
    idle();
    chk("sim_empty", evt_valid, 0);
    chk("sim_rd0_done", rd_outst[3:0], 0);
    chk("sim_wr1_done", wr_outst[7:4], 0);

    // FIFO fill: 10 ARs with ready low, 8 held, 2 dropped, in-order drain
    do_reset();
    evt_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ar_valid = 2'b01; ar_ready = 2'b01; ar_addr[31:0] = 32'h100 + 32'(k * 4);
      tick();
    end
    idle();
    chk("fill_rd0", rd_outst[3:0], 10);
    chk("fill_drop", drop_cnt, 2);
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", evt_valid, 1);
      chk("drain_addr", evt_addr, 32'h100 + 32'(k * 4));
      tick();
    end
    chk("drain_empty", evt_valid, 0);

    // Watchdog: AW on m0, no B
    do_reset();
    aw_valid = 2'b01; aw_ready = 2'b01; aw_addr[31:0] = 32'h3000;
    tick();
    idle();
    for (int k = 1; k < TO; k++) tick();
    chk("wd_before", timeout, 2'b00);
    tick();
    chk("wd_at", timeout, 2'b01);
    b_valid = 2'b01; b_ready = 2'b01;
    tick();
    idle();
    chk("wd_late_b_wr", wr_outst[3:0], 0);
    tick();
    chk("wd_sticky", timeout, 2'b01);

    // Protocol: ar_valid on m1 drops before ready; then B underflow on m0
    do_reset();
    ar_valid = 2'b10; ar_addr[63:32] = 32'h4444;
    tick();
    idle();
    tick();
`ifdef AXI_MON_PROTOCOL_CHECK_EN
    chk("perr_drop", proto_err, 2'b10);
`else
    chk("perr_drop", proto_err, 2'b00);
`endif
    b_valid = 2'b01; b_ready = 2'b01;
    tick();
    idle();
    chk("uf_floor", wr_outst[3:0], 0);
`ifdef AXI_MON_PROTOCOL_CHECK_EN
    chk("perr_uf", proto_err, 2'b11);
`else
    chk("perr_uf", proto_err, 2'b00);
`endif

    // Saturation: 16 AWs on m1, ready low
    do_reset();
    evt_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      aw_valid = 2'b10; aw_ready = 2'b10; aw_addr[63:32] = 32'h5000 + 32'(k);
      tick();
    end
    idle();
    chk("sat_wr1", wr_outst[7:4], 15);
    chk("sat_drop", drop_cnt, 8);
    chk("sat_head_write", evt_write, 1);
    chk("sat_head_master", evt_master, 1);

    // Reset mid-operation with 3 reads outstanding, 2 events queued
    do_reset();
    ar_valid = 2'b11; ar_ready = 2'b11; ar_addr = {32'h6100, 32'h6000};
    tick();
    ar_valid = 2'b01; ar_ready = 2'b01; ar_addr[31:0] = 32'h6004;
    tick();
    chk("pre_rd0", rd_outst[3:0], 2);
    chk("pre_rd1", rd_outst[7:4], 1);
    chk("pre_drop", drop_cnt, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("mid_rd", rd_outst, 0);
    chk("mid_evalid", evt_valid, 0);
    chk("mid_drop", drop_cnt, 0);
    tick();
    chk("mid_still_empty", evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
